// File: rtl/gen_break_multi.sv
// Break controller: halts the core on enabled interrupts or MMIO accesses
// and sequences the stall, timeout and host-resume handshake.
module gen_break_multi #(
   parameter int unsigned NUM_IRQ     = 2,
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_IRQ-1:0]       irq,
   input  logic [NUM_IRQ-1:0]       irq_en,
   input  logic                     irq_full,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH-1:0]        ch_wen,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic                     rd_break_en,
   input  logic                     turn2run,
   input  logic                     clear_err,
   output logic                     break_encore,
   output logic                     irq_mmio,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] hit_ch,
   output logic                     timeout_err,
   output logic [CNT_W-1:0]         break_cnt,
   output logic [2:0]               debug_state
);

   localparam int unsigned HIT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned STALL_W = 16;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      ARMED        = 3'd1,
      MMIO_STALL   = 3'd2,
      IRQ_WAIT_RUN = 3'd3,
      IRQ_DRAIN    = 3'd4,
      RECOVER      = 3'd5,
      TIMEOUT      = 3'd6
   } state_t;

   state_t               state;
   logic [STALL_W-1:0]   stall_cnt;
   logic [NUM_CH-1:0]    hit;
   logic                 irq_act;
   logic                 any_hit;
   logic [HIT_W-1:0]     low_idx;

   assign irq_act      = |(irq & irq_en);
   assign hit          = ch_valid & ch_en & (ch_wen | {NUM_CH{rd_break_en}});
   assign any_hit      = |hit;
   assign break_encore = irq_act | irq_full | irq_mmio;
   assign debug_state  = state;

   // Priority encoder: lowest asserted channel wins.
   always_comb begin
      low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit[i]) low_idx = HIT_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         irq_mmio    <= 1'b0;
         hit_ch      <= '0;
         timeout_err <= 1'b0;
         break_cnt   <= '0;
         stall_cnt   <= '0;
      end else begin
         if (clear_err) timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               irq_mmio <= 1'b0;
               state    <= ARMED;
            end
            ARMED: begin
               if (any_hit) begin
                  irq_mmio  <= 1'b1;
                  hit_ch    <= low_idx;
                  stall_cnt <= '0;
                  if (break_cnt != '1) break_cnt <= break_cnt + CNT_W'(1);
                  state     <= irq_act ? IRQ_WAIT_RUN : MMIO_STALL;
               end
            end
            MMIO_STALL: begin
               stall_cnt <= stall_cnt + STALL_W'(1);
               if (turn2run) begin
                  irq_mmio <= 1'b0;
                  state    <= RECOVER;
               end else if (stall_cnt == STALL_W'(TIMEOUT_CYC - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= TIMEOUT;
               end
            end
            TIMEOUT: begin
               if (turn2run) begin
                  irq_mmio <= 1'b0;
                  state    <= RECOVER;
               end
            end
            IRQ_WAIT_RUN: begin
               if (turn2run) state <= IRQ_DRAIN;
            end
            IRQ_DRAIN: begin
               if (!irq_act) begin
                  irq_mmio <= 1'b0;
                  state    <= RECOVER;
               end
            end
            RECOVER: begin
               state <= ARMED;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gen_break_multi.sv
// Bench for gen_break_multi: directed scenarios plus random traffic, all
// compared every cycle against a behavioural model of the break sequencing.
module tb_gen_break_multi;

   localparam int unsigned NI      = 2;
   localparam int unsigned NC      = 2;
   localparam int unsigned TO      = 4;
   localparam int unsigned CW      = 2;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          reset;
   logic [NI-1:0] irq, irq_en;
   logic          irq_full;
   logic [NC-1:0] ch_valid, ch_wen, ch_en;
   logic          rd_break_en, turn2run, clear_err;
   logic          break_encore, irq_mmio, timeout_err;
   logic [0:0]    hit_ch;
   logic [CW-1:0] break_cnt;
   logic [2:0]    debug_state;

   gen_break_multi #(
      .NUM_IRQ(NI), .NUM_CH(NC), .TIMEOUT_CYC(TO), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .irq(irq), .irq_en(irq_en), .irq_full(irq_full),
      .ch_valid(ch_valid), .ch_wen(ch_wen), .ch_en(ch_en),
      .rd_break_en(rd_break_en), .turn2run(turn2run), .clear_err(clear_err),
      .break_encore(break_encore), .irq_mmio(irq_mmio), .hit_ch(hit_ch),
      .timeout_err(timeout_err), .break_cnt(break_cnt), .debug_state(debug_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit checking = 0;

   // Model: phase number, cycles spent stalled, latched outputs.
   int m_state = 0;
   int m_age   = 0;
   int m_hit   = 0;
   int m_cnt   = 0;
   int m_terr  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int m_mmio();
      return (m_state == 2 || m_state == 3 || m_state == 4 || m_state == 6) ? 1 : 0;
   endfunction

   task automatic model_step();
      int  hidx;
      bit  act;
      if (reset) begin
         m_state = 0; m_age = 0; m_hit = 0; m_cnt = 0; m_terr = 0;
         return;
      end
      act  = ((irq & irq_en) != 0);
      hidx = -1;
      for (int i = 0; i < NC; i++)
         if (hidx < 0 && ch_valid[i] && ch_en[i] && (ch_wen[i] || rd_break_en)) hidx = i;
      if (clear_err) m_terr = 0;
      case (m_state)
         0: m_state = 1;
         1: if (hidx >= 0) begin
               m_hit = hidx;
               if (m_cnt < CNT_MAX) m_cnt++;
               m_age   = 0;
               m_state = act ? 3 : 2;
            end
         2: if (turn2run) m_state = 5;
            else if (m_age + 1 == TO) begin m_state = 6; m_terr = 1; end
            else m_age++;
         3: if (turn2run) m_state = 4;
         4: if (!act) m_state = 5;
         5: m_state = 1;
         6: if (turn2run) m_state = 5;
         default: m_state = 0;
      endcase
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      if (checking) begin
         chk("state", 32'(debug_state), 32'(m_state));
         chk("irq_mmio", 32'(irq_mmio), 32'(m_mmio()));
         chk("hit_ch", 32'(hit_ch), 32'(m_hit));
         chk("break_cnt", 32'(break_cnt), 32'(m_cnt));
         chk("timeout_err", 32'(timeout_err), 32'(m_terr));
         chk("break_encore", 32'(break_encore),
             32'(((irq & irq_en) != 0) || irq_full || (m_mmio() != 0)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      irq = '0; irq_full = 1'b0; ch_valid = '0; ch_wen = '0;
      turn2run = 1'b0; clear_err = 1'b0;
   endtask

   initial begin
      reset = 1'b1; irq_en = '0; ch_en = '0; rd_break_en = 1'b0;
      idle_inputs();
      tick();
      checking = 1;
      tick();
      chk("rst_state", 32'(debug_state), 0);
      chk("rst_mmio", 32'(irq_mmio), 0);
      chk("rst_cnt", 32'(break_cnt), 0);
      chk("rst_terr", 32'(timeout_err), 0);
      reset = 1'b0;
      tick();
      chk("idle_to_armed", 32'(debug_state), 1);
      chk("model_armed", 32'(m_state), 1);

      // Plain write break on channel 0
      ch_valid = 2'b01; ch_wen = 2'b01; ch_en = 2'b11;
      tick(); idle_inputs();
      chk("wr_state", 32'(debug_state), 2);
      chk("wr_mmio", 32'(irq_mmio), 1);
      chk("wr_hit", 32'(hit_ch), 0);
      chk("wr_cnt", 32'(break_cnt), 1);
      turn2run = 1'b1; tick(); turn2run = 1'b0;
      chk("wr_recover", 32'(debug_state), 5);
      chk("wr_rec_mmio", 32'(irq_mmio), 0);
      tick();
      chk("wr_rearm", 32'(debug_state), 1);

      // Both channels hit with an enabled interrupt pending
      ch_valid = 2'b11; ch_wen = 2'b11; irq = 2'b01; irq_en = 2'b01;
      tick(); ch_valid = '0; ch_wen = '0;
      chk("pri_state", 32'(debug_state), 3);
      chk("pri_hit", 32'(hit_ch), 0);
      chk("pri_cnt", 32'(break_cnt), 2);
      turn2run = 1'b1; tick(); turn2run = 1'b0;
      chk("pri_drain", 32'(debug_state), 4);
      irq_full = 1'b1; tick();
      chk("pri_hold", 32'(debug_state), 4);
      irq = '0; irq_full = 1'b0; tick();
      chk("pri_recover", 32'(debug_state), 5);
      chk("pri_mmio", 32'(irq_mmio), 0);
      tick();

      // Channel 1 break, then stall until timeout
      ch_valid = 2'b10; ch_wen = 2'b10;
      tick(); idle_inputs();
      chk("ch1_hit", 32'(hit_ch), 1);
      chk("ch1_cnt", 32'(break_cnt), 3);
      repeat (3) tick();
      chk("to_still_stall", 32'(debug_state), 2);
      tick();
      chk("to_state", 32'(debug_state), 6);
      chk("to_err", 32'(timeout_err), 1);
      chk("to_mmio", 32'(irq_mmio), 1);
      chk("model_to_err", 32'(m_terr), 1);
      clear_err = 1'b1; tick(); clear_err = 1'b0;
      chk("clr_err", 32'(timeout_err), 0);
      turn2run = 1'b1; tick(); turn2run = 1'b0;
      chk("to_recover", 32'(debug_state), 5);
      tick();

      // Read filter
      ch_valid = 2'b01; ch_wen = 2'b00; rd_break_en = 1'b0;
      tick();
      chk("rd_blocked", 32'(debug_state), 1);
      rd_break_en = 1'b1; tick(); idle_inputs(); rd_break_en = 1'b0;
      chk("rd_break", 32'(debug_state), 2);
      turn2run = 1'b1; tick(); turn2run = 1'b0; tick();

      // Fifth break saturates the counter, then reset mid-stall
      ch_valid = 2'b01; ch_wen = 2'b01;
      tick(); idle_inputs();
      chk("sat_cnt", 32'(break_cnt), 3);
      chk("model_sat", 32'(m_cnt), 3);
      irq_full = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_state", 32'(debug_state), 0);
      chk("mid_rst_mmio", 32'(irq_mmio), 0);
      chk("mid_rst_cnt", 32'(break_cnt), 0);
      chk("mid_rst_hit", 32'(hit_ch), 0);
      #1;
      chk("mid_rst_enc_full", 32'(break_encore), 1);
      irq_full = 1'b0; #1;
      chk("mid_rst_enc_idle", 32'(break_encore), 0);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         reset       = ($urandom_range(0, 99) == 0);
         ch_valid    = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
         ch_wen      = NC'($urandom);
         ch_en       = NC'($urandom);
         rd_break_en = $urandom_range(0, 1) == 1;
         irq         = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
         irq_en      = NI'($urandom);
         irq_full    = ($urandom_range(0, 15) == 0);
         turn2run    = ($urandom_range(0, 3) == 0);
         clear_err   = ($urandom_range(0, 15) == 0);
         tick();
      end

      reset = 1'b0; idle_inputs();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gen_break_multi.md
GEN_BREAK_MULTI -- requirements
Module: gen_break_multi

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 2: number of interrupt break sources.
REQ-002 SHALL have parameter NUM_CH, default 2: number of MMIO access channels.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: MMIO stall cycles before timeout; legal range 1 to 65535.
REQ-004 SHALL have parameter CNT_W, default 8: width of the break event counter.
REQ-005 SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have the port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have the port irq, input, NUM_IRQ bits: interrupt requests.
REQ-008 SHALL have the port irq_en, input, NUM_IRQ bits: per-interrupt mask, 1 = enabled.
REQ-009 SHALL have the port irq_full, input, 1 bit: interrupt queue full.
REQ-010 SHALL have the port ch_valid, input, NUM_CH bits: per-channel MMIO access valid.
REQ-011 SHALL have the port ch_wen, input, NUM_CH bits: per-channel write enable.
REQ-012 SHALL have the port ch_en, input, NUM_CH bits: per-channel break enable.
REQ-013 SHALL have the port rd_break_en, input, 1 bit: MMIO reads also break.
REQ-014 SHALL have the port turn2run, input, 1 bit: host resume pulse.
REQ-015 SHALL have the port clear_err, input, 1 bit: clears timeout_err.
REQ-016 SHALL have the port break_encore, output, 1 bit: core halt request.
REQ-017 SHALL have the port irq_mmio, output, 1 bit: MMIO break active.
REQ-018 SHALL have the port hit_ch, output, $clog2(NUM_CH) bits (minimum 1): channel index of the last MMIO break.
REQ-019 SHALL have the port timeout_err, output, 1 bit: sticky stall-timeout flag.
REQ-020 SHALL have the port break_cnt, output, CNT_W bits: count of MMIO breaks.
REQ-021 SHALL have the port debug_state, output, 3 bits: current state encoding.

Function
REQ-022 SHALL use states IDLE=0, ARMED=1, MMIO_STALL=2, IRQ_WAIT_RUN=3, IRQ_DRAIN=4, RECOVER=5, TIMEOUT=6; debug_state = state.
REQ-023 SHALL define irq_act = |(irq & irq_en) and drive break_encore = irq_act | irq_full | irq_mmio combinationally.
REQ-024 SHALL define, for channel i, hit[i] = ch_valid[i] & ch_en[i] & (ch_wen[i] | rd_break_en).
REQ-025 SHALL go from IDLE to ARMED after one cycle, with irq_mmio=0.
REQ-026 SHALL, in ARMED on any hit: set irq_mmio=1, latch the lowest asserted hit index into hit_ch, increment break_cnt (saturating at all-ones), then go to IRQ_WAIT_RUN if irq_act else to MMIO_STALL.
REQ-027 SHALL stay in ARMED with outputs held when no hit occurs; turn2run is ignored in ARMED.
REQ-028 SHALL, in MMIO_STALL: load a 16-bit stall counter with 0 on entry and increment it each cycle; go to RECOVER on turn2run; otherwise go to TIMEOUT in the cycle the counter equals TIMEOUT_CYC-1; turn2run wins if both occur.
REQ-029 SHALL set timeout_err=1 on entry to TIMEOUT; hold irq_mmio=1; go to RECOVER on turn2run.
REQ-030 SHALL, in IRQ_WAIT_RUN, go to IRQ_DRAIN on turn2run and otherwise hold.
REQ-031 SHALL, in IRQ_DRAIN, go to RECOVER when irq_act=0 and otherwise hold; irq_full has no effect on this transition.
REQ-032 SHALL clear irq_mmio on entry to RECOVER and go from RECOVER to ARMED after exactly one cycle; a hit during RECOVER is ignored.
REQ-033 SHALL clear timeout_err when clear_err=1; if clear_err and entry to TIMEOUT occur in the same cycle, the set wins.
REQ-034 SHALL treat unused encoding 7 as IDLE on the next cycle.
REQ-035 SHALL leave hit_ch and break_cnt unchanged except on an ARMED hit.

Reset
REQ-036 SHALL, when reset=1 at a clock edge, set state=IDLE, irq_mmio=0, hit_ch=0, timeout_err=0, break_cnt=0 and the stall counter to 0, overriding every other input.
REQ-037 SHALL abandon any in-progress stall when reset is asserted mid-operation; break_encore then follows only irq_act | irq_full.

Verification
REQ-038 SHALL cover plain write break: ch_valid=01, ch_wen=01, ch_en=11, irq=0 in ARMED -> next cycle irq_mmio=1, state=2, hit_ch=0, break_cnt=1; turn2run -> state=5, then state=1.
REQ-039 SHALL cover priority with a masked interrupt: ch_valid=11 with writes, irq=01, irq_en=01 -> state=3, hit_ch=0; turn2run -> state=4; irq drops -> state=5 and irq_mmio=0.
REQ-040 SHALL cover timeout: TIMEOUT_CYC=4, hit, no turn2run -> state=6 four cycles after entering MMIO_STALL and timeout_err=1; clear_err -> timeout_err=0.
REQ-041 SHALL cover the read filter: ch_wen=0 with rd_break_en=0 -> no break; with rd_break_en=1 -> break occurs.
REQ-042 SHALL cover saturation: CNT_W=2 and 5 breaks -> break_cnt=3.
REQ-043 SHALL cover reset mid-operation: reset in state 2 -> next cycle state=0 and all outputs 0, and break_encore = irq_full.
